prod_accum: RTL and testbench

Streaming dot-product accumulator that sits directly downstream of the signed 4x4 Booth multiplier. It takes one signed 8-bit product per accepted transfer and sums LEN consecutive products into a wider signed accumulator. It then presents the finished sum on a valid/ready output port and holds it until the consumer takes it.

---
 rtl/prod_acc_pkg.sv | 30 +++
 rtl/prod_acc_add.sv | 39 +++
 rtl/prod_accum.sv | 105 ++++++++++
 tb/tb_prod_accum.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/prod_acc_pkg.sv
// prod_acc_pkg: shared types and defaults for the prod_accum slice.
//   state_t     : accumulator FSM states (ACCUM, HOLD)
//   *_DEF       : default product width, accumulator width and dot-product length
//   clog2/cnt_w : count-width helpers (cnt_w never returns less than 1 bit)
package prod_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam int PROD_W_DEF = 8;
  localparam int ACC_W_DEF  = 16;
  localparam int LEN_DEF    = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // LEN = 1 still needs a 1-bit counter so the vector stays legal.
  function automatic int cnt_w(input int len);
    return (len > 1) ? clog2(len) : 1;
  endfunction

endpackage

// File: rtl/prod_acc_add.sv
// prod_acc_add: ACC_W signed adder of accumulator + sign-extended product,
// with two's-complement overflow detect.
// Optional feature macro: PROD_ACC_SAT_EN -- when defined the sum saturates to
// the most positive / most negative ACC_W value on overflow; otherwise it wraps.
//   acc  : current signed accumulator value
//   prod : signed product to add
//   sum  : next accumulator value (wrapped or saturated)
//   ovf  : this add overflowed
module prod_acc_add
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [PROD_W-1:0] prod,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     ovf
);

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] raw;

  // Size cast of a signed operand sign-extends.
  assign prod_ext = ACC_W'(prod);
  assign raw      = acc + prod_ext;
  assign ovf      = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);

`ifdef PROD_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // On overflow both operands share a sign, so acc's sign picks the rail.
  assign sum = ovf ? (acc[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw;
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/prod_accum.sv
// prod_accum: streaming dot-product accumulator behind the Booth multiplier.
// Sums LEN consecutive signed products and presents the result on a
// valid/ready port, holding it until taken.
// Optional feature macro: PROD_ACC_SAT_EN (saturating adds, see prod_acc_add).
//   clk, rst            : rising-edge clock, async active-high reset
//   in_valid/in_ready   : product handshake; in_prod is the signed product
//   in_clear            : synchronous abort of the partial sum (ignored in HOLD)
//   out_valid/out_ready : result handshake
//   out_acc, out_ovf    : finished sum and its sticky overflow flag
//
// state | meaning
// ------+------------------------------------------------------------
// ACCUM | accepting products, building the partial sum
// HOLD  | result registered on out_acc/out_ovf, waiting for out_ready
module prod_accum
  import prod_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN    = LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic                     out_ovf
);

  localparam int              CNT_W    = cnt_w(LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0]        cnt;
  logic                    flag, add_ovf;
  logic                    in_hs, out_hs, last;

  prod_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc  (acc),
    .prod (in_prod),
    .sum  (acc_sum),
    .ovf  (add_ovf)
  );

  // rst gates in_ready so it reads low for the whole reset window,
  // including an asynchronous reset in the middle of a cycle.
  assign in_ready = (state == ACCUM) && !in_clear && !rst;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last     = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (in_hs && last) state_nxt = HOLD;
      HOLD:  if (out_hs)        state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      flag      <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (state == ACCUM) begin
      if (in_clear) begin
        acc  <= '0;
        cnt  <= '0;
        flag <= 1'b0;
      end else if (in_hs) begin
        if (last) begin
          out_acc   <= acc_sum;
          out_ovf   <= flag | add_ovf;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          flag      <= 1'b0;
        end else begin
          acc  <= acc_sum;
          cnt  <= cnt + CNT_W'(1);
          flag <= flag | add_ovf;
        end
      end
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prod_accum.sv
module tb_prod_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_clear = 1'b0;
  logic out_ready = 1'b0;
  logic signed [7:0] in_prod = '0;

  logic in_ready, out_valid, out_ovf;
  logic signed [15:0] out_acc;
  logic in_ready8, out_valid8, out_ovf8;
  logic signed [7:0] out_acc8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prod_accum u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_clear(in_clear), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  prod_accum #(.PROD_W(8), .ACC_W(8), .LEN(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .in_prod(in_prod), .in_clear(in_clear), .out_valid(out_valid8),
    .out_ready(out_ready), .out_acc(out_acc8), .out_ovf(out_ovf8)
  );

  typedef struct {
    int p0, p1, p2, p3;
    int e16; int o16;
    int e8w; int o8w;
    int e8s; int o8s;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain integer sum with range check after every add.
  function automatic longint ref_sum(input int p[4], input int w, output int ovf);
    longint mx, mn, a, s;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    a   = 0;
    ovf = 0;
    for (int i = 0; i < 4; i++) begin
      s = a + longint'(p[i]);
      if (s > mx || s < mn) begin
        ovf = 1;
`ifdef PROD_ACC_SAT_EN
        a = (s > mx) ? mx : mn;
`else
        a = (s > mx) ? s - 2 * (mx + 1) : s + 2 * (mx + 1);
`endif
      end else begin
        a = s;
      end
    end
    return a;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic push(input int p);
    int g;
    in_valid = 1'b1;
    in_prod  = 8'(p);
    g = 0;
    #1;
    while (!(in_ready && in_ready8) && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 20) begin
      bad++;
      total++;
      $display("FAIL push timeout: in_ready=%0d in_ready8=%0d expected 1", in_ready, in_ready8);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic take(input string nm, input int e16, input int o16,
                      input int e8, input int o8, input int stall);
    check({nm, " valid"}, out_valid, 1);
    check({nm, " valid8"}, out_valid8, 1);
    check({nm, " acc"}, out_acc, e16);
    check({nm, " ovf"}, out_ovf, o16);
    check({nm, " acc8"}, out_acc8, e8);
    check({nm, " ovf8"}, out_ovf8, o8);
    check({nm, " hold rdy"}, in_ready | in_ready8, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({nm, " stall valid"}, out_valid & out_valid8, 1);
      check({nm, " stall acc"}, out_acc, e16);
      check({nm, " stall acc8"}, out_acc8, e8);
      check({nm, " stall rdy"}, in_ready | in_ready8, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, " drop valid"}, out_valid | out_valid8, 0);
    check({nm, " rdy back"}, in_ready & in_ready8, 1);
  endtask

  task automatic do_clear(input logic v, input int p);
    in_clear = 1'b1;
    in_valid = v;
    in_prod  = 8'(p);
    #1;
    check("clear rdy", in_ready | in_ready8, 0);
    @(negedge clk);
    in_clear = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    int p[4];
    int o16, o8, cnt, e8;
    longint r16, r8;

    vecs[0] = '{10, -3, 7, 2,      16, 0,   16, 0,   16, 0};
    vecs[1] = '{-128, -128, -128, -128, -512, 0, 0, 1, -128, 1};
    vecs[2] = '{127, 127, 127, 127, 508, 0,  -4, 1,  127, 1};
    vecs[3] = '{100, 100, 0, 0,    200, 0,  -56, 1,  127, 1};
    vecs[4] = '{1, 1, 1, 1,          4, 0,    4, 0,    4, 0};
    vecs[5] = '{-100, -100, 50, 0, -150, 0, 106, 1,  -78, 1};

    // reset state
    #2;
    check("rst valid", out_valid | out_valid8, 0);
    check("rst acc", out_acc, 0);
    check("rst acc8", out_acc8, 0);
    check("rst ovf", out_ovf | out_ovf8, 0);
    check("rst rdy", in_ready | in_ready8, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post rst rdy", in_ready & in_ready8, 1);

    // table vectors, latency checked right after the 4th acceptance
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].p0);
      push(vecs[i].p1);
      push(vecs[i].p2);
      check($sformatf("vec%0d early valid", i), out_valid | out_valid8, 0);
      push(vecs[i].p3);
`ifdef PROD_ACC_SAT_EN
      take($sformatf("vec%0d", i), vecs[i].e16, vecs[i].o16, vecs[i].e8s, vecs[i].o8s, 0);
`else
      take($sformatf("vec%0d", i), vecs[i].e16, vecs[i].o16, vecs[i].e8w, vecs[i].o8w, 0);
`endif
    end

    // backpressure: 5 stalled cycles with a product waiting
    push(10); push(-3); push(7); push(2);
    in_valid = 1'b1;
    in_prod  = 8'sd99;
    take("bp", 16, 0, 16, 0, 5);
    in_valid = 1'b0;
    push(1); push(2); push(3); push(4);
    take("bp next", 10, 0, 10, 0, 0);

    // clear wins over a simultaneous product
    push(5); push(6);
    do_clear(1'b1, 9);
    push(1); push(2); push(3);
    check("clr early valid", out_valid | out_valid8, 0);
    push(4);
    take("clr", 10, 0, 10, 0, 0);

    // async reset with a partial sum
    push(1); push(1);
    #2;
    rst = 1'b1;
    #1;
    check("mid rst valid", out_valid | out_valid8, 0);
    check("mid rst rdy", in_ready | in_ready8, 0);
    @(negedge clk);
    rst = 1'b0;
    push(1); push(1); push(1);
    check("rst1 early valid", out_valid | out_valid8, 0);
    push(1);
    take("after rst", 4, 0, 4, 0, 0);

    // async reset while holding a result
    push(20); push(20); push(20); push(20);
    check("hold pre rst", out_valid & out_valid8, 1);
    #2;
    rst = 1'b1;
    #1;
    check("hold rst valid", out_valid | out_valid8, 0);
    check("hold rst acc", out_acc, 0);
    check("hold rst rdy", in_ready | in_ready8, 0);
    @(negedge clk);
    rst = 1'b0;
    push(1); push(1); push(1); push(1);
    take("after hold rst", 4, 0, 4, 0, 0);

    // randomized dot products with gaps, clears and stalls
    for (int n = 0; n < 30; n++) begin
      cnt = 0;
      while (cnt < 4) begin
        if ($urandom_range(0, 9) == 0) begin
          do_clear(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
          cnt = 0;
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        p[cnt] = int'($urandom_range(0, 255)) - 128;
        push(p[cnt]);
        cnt++;
      end
      r16 = ref_sum(p, 16, o16);
      r8  = ref_sum(p, 8, o8);
      e8  = int'(r8);
      take($sformatf("rnd%0d", n), int'(r16), o16, e8, o8, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
